maj_net_eval: RTL and testbench
===============================

Name: maj_net_eval

Overview:
- Sequential, programmable evaluator for majority (MAJ3) networks over N_IN primary inputs.
- Generalises the fixed 7-input majority chains used in function classification: node topology is loaded at runtime; nodes are evaluated one per clock.
- Sits between the classification vector generator (stimulus side) and the truth-table collector (result side).
- Uses a valid/ready handshake on both sides.

Parameters:
- N_IN, 7, number of primary inputs x[N_IN-1:0].
- N_NODES, 8, maximum number of MAJ3 nodes in the program store.
- SEL_W, $clog2(1+N_IN+N_NODES), operand select width (derived; do not override).
- LEN_W, $clog2(N_NODES+1), width of the program length field (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  program write strobe; takes effect only when cfg_ready=1.
- cfg_addr  in  $clog2(N_NODES)  node index to write.
- cfg_data  in  3*SEL_W (+3 with MAJ_INV_EN)  operand selects {c,b,a}, plus complement bits when the feature is enabled.
- cfg_len_we  in  1  program length write strobe; takes effect only when cfg_ready=1.
- cfg_len  in  LEN_W  number of active nodes.
- cfg_ready  out  1  high in IDLE.
- in_valid  in  1  input vector valid.
- in_ready  out  1  high in IDLE.
- in_x  in  N_IN  primary input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_y  out  1  value of the last active node.
- out_err  out  1  a forward or illegal reference occurred during this evaluation.

Behaviour:
- Operand encoding:
  - 0 = constant 0.
  - 1..N_IN = in_x[sel-1].
  - N_IN+1..N_IN+N_NODES = result of node sel-N_IN-1.
- Node k computes MAJ(a,b,c) = ab|ac|bc.
- A select that names node j>=k, or a value above the encoded range, reads 0 and sets err.
- FSM states IDLE, EVAL, DONE.
  - IDLE: in_ready=cfg_ready=1. On in_valid:
    - latch in_x;
    - clear the node result register and err;
    - set k=0;
    - go to EVAL.
    - If the latched length is 0, go directly to DONE with y=0.
  - EVAL: one node per cycle; result stored in node_reg[k]; k increments.
    - After node len-1, go to DONE.
    - in_ready=0.
  - DONE: out_valid=1, with out_y=node_reg[len-1] and out_err held stable.
    - When out_valid&out_ready, return to IDLE.
    - Holds indefinitely under backpressure.
- Latency: in-accept cycle to out_valid is len+1 cycles (1 for len=0).
  - Maximum throughput: one vector per len+2 cycles.
- cfg_len greater than N_NODES is clamped to N_NODES when written.
- Config writes and in_valid in the same IDLE cycle:
  - the write commits;
  - the evaluation uses the pre-write program;
  - the new program applies from the next vector.
- cfg_we while not in IDLE: the write is dropped with no side effect.
- Reset (any state, mid-evaluation included):
  - state=IDLE;
  - out_valid=0, out_y=0, out_err=0;
  - k=0;
  - node_reg=0;
  - program store all zeros, cfg_len=0.
  - The in-flight vector is discarded.

Optional Feature:
- Macro: MAJ_NET_INV_EN.
- When defined:
  - cfg_data gains 3 complement bits {inv_c,inv_b,inv_a} at the LSBs.
  - Each selected operand is XORed with its bit before the majority (full majority-inverter graph). Constant 0 with its complement bit set yields 1.
  - An illegal reference reads 0 and is then complemented.
- When undefined:
  - cfg_data is exactly 3*SEL_W bits.
  - No inversion is possible; the network is monotone.

Decomposition:
- Package maj_net_pkg holds:
  - the function for SEL_W/LEN_W derivation;
  - the state enum {IDLE,EVAL,DONE};
  - operand-region constants (SEL_ZERO=0, SEL_X_BASE=1, SEL_N_BASE=N_IN+1);
  - the node config struct (a, b, c, and inv when enabled).
- Sub-module maj_net_operand_mux: given a select value, in_x, node_reg and the current k, returns the operand bit and an illegal flag.
  - It is instantiated three times.

Test Plan:
- Program 6 nodes: n0=M(x2,x3,x4), n1=M(x0,x6,n0), n2=M(x1,x5,n1), n3=M(x0,x2,n2), n4=M(x0,x3,x4), n5=M(x1,n3,n4); len=6.
  - in_x=7'b0000111 -> out_y=1 on the 7th cycle after accept, err=0.
  - in_x=7'b0000011 -> out_y=0.
  - in_x=0 -> out_y=0.
  - in_x=all ones -> out_y=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, out_y and out_err stay stable; in_ready=0 throughout; one accept, then return to IDLE.
- Forward reference: set n0.a=select of n1 with len=2 -> out_err=1, and that operand is treated as 0.
- len=0 -> out_valid one cycle after accept, out_y=0.
- cfg_len=15 with N_NODES=8 -> reads back/behaves as 8.
- cfg_we during EVAL is dropped, verified by the next vector's result.
- rst_n=0 asserted mid-EVAL -> next cycle IDLE with out_valid=0, and the program is cleared.
- MAJ_NET_INV_EN: n0=M(~0,x0,x1), len=1 -> out_y = x0|x1 for all 4 combinations.

Source files
------------

// File: rtl/maj_net_pkg.sv
// Shared types, width helpers and operand-region constants for the MAJ3 network evaluator.
// With MAJ_NET_INV_EN defined, node_cfg_t carries per-operand complement bits at the LSBs.
package maj_net_pkg;

    localparam int DEF_N_IN    = 7;
    localparam int DEF_N_NODES = 8;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int sel_width(input int n_in, input int n_nodes);
        return clog2_f(1 + n_in + n_nodes);
    endfunction

    function automatic int len_width(input int n_nodes);
        return clog2_f(n_nodes + 1);
    endfunction

    function automatic int idx_width(input int n_nodes);
        return (n_nodes > 1) ? clog2_f(n_nodes) : 1;
    endfunction

    // Select space: 0 = constant, then primary inputs, then node results.
    localparam int SEL_ZERO   = 0;
    localparam int SEL_X_BASE = 1;
    localparam int SEL_N_BASE = DEF_N_IN + 1;

    localparam int DEF_SEL_W = sel_width(DEF_N_IN, DEF_N_NODES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_SEL_W-1:0] c;
        logic [DEF_SEL_W-1:0] b;
        logic [DEF_SEL_W-1:0] a;
`ifdef MAJ_NET_INV_EN
        logic [2:0]           inv;
`endif
    } node_cfg_t;

endpackage

// File: rtl/maj_net_operand_mux.sv
// Resolves one operand select into a bit: constant, primary input or an earlier node result.
// Selects naming the current or a later node, or beyond the encoded range, read 0 and flag illegal.
module maj_net_operand_mux
    import maj_net_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_NODES = DEF_N_NODES,
    parameter int SEL_W   = sel_width(N_IN, N_NODES),
    parameter int K_W     = idx_width(N_NODES)
) (
    input  logic [SEL_W-1:0]   sel,
    input  logic [N_IN-1:0]    x,
    input  logic [N_NODES-1:0] nodes,
    input  logic [K_W-1:0]     k,
    output logic               operand,
    output logic               illegal
);

    localparam int N_BASE = SEL_N_BASE + (N_IN - DEF_N_IN);

    logic [N_IN-1:0]    x_hit;
    logic [N_NODES-1:0] n_hit;
    logic [N_NODES-1:0] n_fwd;
    logic               is_zero;
    logic               over;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_x
            assign x_hit[gi] = (int'(sel) == SEL_X_BASE + gi);
        end
        for (genvar gi = 0; gi < N_NODES; gi++) begin : g_n
            assign n_hit[gi] = (int'(sel) == N_BASE + gi);
            // Node gi is only computed once k has moved past it.
            assign n_fwd[gi] = n_hit[gi] && (gi >= int'(k));
        end
    endgenerate

    assign is_zero = (int'(sel) == SEL_ZERO);
    assign over    = (int'(sel) >= N_BASE + N_NODES);
    assign operand = !is_zero && ((|(x_hit & x)) || (|(n_hit & ~n_fwd & nodes)));
    assign illegal = over || (|n_fwd);

endmodule

// File: rtl/maj_net_eval.sv
// Programmable MAJ3 network evaluator: one node per clock, valid/ready on both sides.
// Optional MAJ_NET_INV_EN adds complement bits per operand (majority-inverter graph).
module maj_net_eval
    import maj_net_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int N_NODES = DEF_N_NODES,
    parameter int SEL_W   = sel_width(N_IN, N_NODES),
    parameter int LEN_W   = len_width(N_NODES),
    parameter int ADDR_W  = idx_width(N_NODES),
    parameter int CFG_W   = $bits(node_cfg_t)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              cfg_len_we,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              cfg_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              out_err
);

    state_t             state_reg, state_next;
    node_cfg_t          prog_reg     [N_NODES];
    node_cfg_t          run_prog_reg [N_NODES];
    logic [LEN_W-1:0]   len_reg, run_len_reg, len_clamped;
    logic [ADDR_W-1:0]  k_reg;
    logic [N_IN-1:0]    x_reg;
    logic [N_NODES-1:0] node_reg;
    logic               err_reg, y_reg;

    node_cfg_t          cur;
    logic [SEL_W-1:0]   op_sel [3];
    logic [2:0]         op_raw, op_ill, op_inv, op_val;
    logic               node_val, last_node, idle;

    assign idle = (state_reg == IDLE);
    // Evaluation runs from a snapshot so same-cycle config writes only affect later vectors.
    assign cur  = run_prog_reg[k_reg];

    assign op_sel[0] = cur.a;
    assign op_sel[1] = cur.b;
    assign op_sel[2] = cur.c;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_op
            maj_net_operand_mux #(
                .N_IN    (N_IN),
                .N_NODES (N_NODES),
                .SEL_W   (SEL_W),
                .K_W     (ADDR_W)
            ) u_mux (
                .sel     (op_sel[gi]),
                .x       (x_reg),
                .nodes   (node_reg),
                .k       (k_reg),
                .operand (op_raw[gi]),
                .illegal (op_ill[gi])
            );
        end
    endgenerate

`ifdef MAJ_NET_INV_EN
    assign op_inv = cur.inv;
`else
    assign op_inv = 3'b000;
`endif

    assign op_val      = op_raw ^ op_inv;
    assign node_val    = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
    assign last_node   = (LEN_W'(k_reg) == run_len_reg - LEN_W'(1));
    assign len_clamped = (cfg_len > LEN_W'(N_NODES)) ? LEN_W'(N_NODES) : cfg_len;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = (len_reg == '0) ? DONE : EVAL;
            EVAL: if (last_node) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            len_reg     <= '0;
            run_len_reg <= '0;
            x_reg       <= '0;
            node_reg    <= '0;
            err_reg     <= 1'b0;
            y_reg       <= 1'b0;
            for (int i = 0; i < N_NODES; i++) begin
                prog_reg[i]     <= '0;
                run_prog_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (idle && cfg_we)     prog_reg[cfg_addr] <= node_cfg_t'(cfg_data);
            if (idle && cfg_len_we) len_reg            <= len_clamped;
            case (state_reg)
                IDLE: if (in_valid) begin
                    x_reg        <= in_x;
                    node_reg     <= '0;
                    err_reg      <= 1'b0;
                    y_reg        <= 1'b0;
                    k_reg        <= '0;
                    run_len_reg  <= len_reg;
                    run_prog_reg <= prog_reg;
                end
                EVAL: begin
                    node_reg[k_reg] <= node_val;
                    err_reg         <= err_reg | (|op_ill);
                    k_reg           <= k_reg + 1'b1;
                    if (last_node) y_reg <= node_val;
                end
                default: ;
            endcase
        end
    end

    assign cfg_ready = idle;
    assign in_ready  = idle;
    assign out_valid = (state_reg == DONE);
    assign out_y     = y_reg;
    assign out_err   = err_reg;

endmodule

// File: tb/tb_maj_net_eval.sv
// Randomised and directed bench for maj_net_eval against a node-by-node reference model.
module tb_maj_net_eval;

    localparam int N_IN    = 7;
    localparam int N_NODES = 8;
    localparam int SEL_W   = 4;
    localparam int LEN_W   = 4;
    localparam int ADDR_W  = 3;
`ifdef MAJ_NET_INV_EN
    localparam int CFG_W = 3 * SEL_W + 3;
`else
    localparam int CFG_W = 3 * SEL_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CFG_W-1:0]  cfg_data = '0;
    logic              cfg_len_we = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              cfg_ready;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N_IN-1:0]   in_x = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_y;
    logic              out_err;

    maj_net_eval dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference program: operand selects, complement bits and active length.
    int m_a [N_NODES];
    int m_b [N_NODES];
    int m_c [N_NODES];
    int m_inv [N_NODES];
    int m_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N_NODES; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_c[i] = 0; m_inv[i] = 0;
        end
        m_len = 0;
    endfunction

    function automatic void model_set(input int addr, input int a, input int b, input int c, input int inv);
        m_a[addr] = a;
        m_b[addr] = b;
        m_c[addr] = c;
`ifdef MAJ_NET_INV_EN
        m_inv[addr] = inv & 7;
`else
        m_inv[addr] = 0 * inv;
`endif
    endfunction

    function automatic void model_eval(input logic [N_IN-1:0] x, output logic y, output logic err);
        logic v [N_NODES];
        int   sel [3];
        int   cnt;
        logic val;
        logic [N_IN-1:0] sh;
        err = 1'b0;
        y   = 1'b0;
        for (int k = 0; k < N_NODES; k++) v[k] = 1'b0;
        for (int k = 0; k < m_len; k++) begin
            sel[0] = m_a[k]; sel[1] = m_b[k]; sel[2] = m_c[k];
            cnt = 0;
            for (int o = 0; o < 3; o++) begin
                if (sel[o] == 0) begin
                    val = 1'b0;
                end else if (sel[o] <= N_IN) begin
                    sh  = x >> (sel[o] - 1);
                    val = sh[0];
                end else if (sel[o] <= N_IN + N_NODES && (sel[o] - N_IN - 1) < k) begin
                    val = v[sel[o] - N_IN - 1];
                end else begin
                    val = 1'b0;
                    err = 1'b1;
                end
                if (((m_inv[k] >> o) & 1) != 0) val = ~val;
                cnt += int'(val);
            end
            v[k] = (cnt >= 2);
        end
        if (m_len > 0) y = v[m_len - 1];
    endfunction

    function automatic logic [CFG_W-1:0] pack_cfg(input int a, input int b, input int c, input int inv);
`ifdef MAJ_NET_INV_EN
        return {SEL_W'(c), SEL_W'(b), SEL_W'(a), 3'(inv)};
`else
        return {SEL_W'(c), SEL_W'(b), SEL_W'(a)} | CFG_W'(0 * inv);
`endif
    endfunction

    task automatic prog_node(input int addr, input int a, input int b, input int c, input int inv);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_W'(addr);
        cfg_data = pack_cfg(a, b, c, inv);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        model_set(addr, a, b, c, inv);
    endtask

    task automatic set_len(input int l);
        @(negedge clk);
        cfg_len_we = 1'b1;
        cfg_len    = LEN_W'(l);
        @(posedge clk);
        #1 cfg_len_we = 1'b0;
        m_len = (l > N_NODES) ? N_NODES : l;
    endtask

    // mode 0: plain; 1: config write in the accept cycle; 2: config write during EVAL (dropped).
    task automatic run_vec(input logic [N_IN-1:0] x, input int hold, input int mode,
                           input int w_addr, input int w_a, input int w_b, input int w_c, input int w_inv);
        logic ey, ee;
        int   lat;
        bit   seen;
        int   exp_lat;
        model_eval(x, ey, ee);
        exp_lat = m_len + 1;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_x     = x;
        if (mode == 1) begin
            cfg_we   = 1'b1;
            cfg_addr = ADDR_W'(w_addr);
            cfg_data = pack_cfg(w_a, w_b, w_c, w_inv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (mode == 1) model_set(w_addr, w_a, w_b, w_c, w_inv);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mode == 2 && lat == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = ADDR_W'(w_addr);
                cfg_data = pack_cfg(w_a, w_b, w_c, w_inv);
            end
            if (mode == 2 && lat == 2) cfg_we = 1'b0;
            if (out_valid) seen = 1'b1;
            else chk("in_ready_busy", 32'(in_ready), 0);
        end
        cfg_we = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("out_y", 32'(out_y), 32'(ey));
        chk("out_err", 32'(out_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_y", 32'(out_y), 32'(ey));
            chk("hold_err", 32'(out_err), 32'(ee));
            chk("hold_in_ready", 32'({in_ready, cfg_ready}), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("back_idle", 32'({out_valid, in_ready}), 1);
        $display("txn x=%b len=%0d mode=%0d hold=%0d y=%b err=%b lat=%0d", x, m_len, mode, hold, ey, ee, lat);
    endtask

    task automatic load_spec_prog();
        prog_node(0, 3, 4, 5, 0);
        prog_node(1, 1, 7, 8, 0);
        prog_node(2, 2, 6, 9, 0);
        prog_node(3, 1, 3, 10, 0);
        prog_node(4, 1, 4, 5, 0);
        prog_node(5, 2, 11, 12, 0);
        set_len(6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_y", 32'(out_y), 0);
        chk("rst_out_err", 32'(out_err), 0);
        chk("rst_ready", 32'({in_ready, cfg_ready}), 3);
        rst_n = 1'b1;

        // Program from the test plan and its four reference vectors.
        load_spec_prog();
        run_vec(7'b0000111, 0, 0, 0, 0, 0, 0, 0);
        run_vec(7'b0000011, 0, 0, 0, 0, 0, 0, 0);
        run_vec(7'b0000000, 0, 0, 0, 0, 0, 0, 0);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);
        run_vec(7'b1010101, 10, 0, 0, 0, 0, 0, 0);

        // Same-cycle write: old program for this vector, new one afterwards.
        run_vec(7'b1111111, 0, 1, 5, 0, 0, 0, 0);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);
        prog_node(5, 2, 11, 12, 0);
        // Write during EVAL must be dropped.
        run_vec(7'b1111111, 0, 2, 5, 0, 0, 0, 0);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);

        // Forward reference.
        prog_node(0, 9, 1, 2, 0);
        prog_node(1, 1, 2, 3, 0);
        set_len(2);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);

        // Zero-length program.
        set_len(0);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);

        // Oversized length clamps to N_NODES.
        load_spec_prog();
        prog_node(6, 13, 1, 2, 0);
        prog_node(7, 14, 3, 4, 0);
        set_len(15);
        run_vec(7'b0000111, 0, 0, 0, 0, 0, 0, 0);
        run_vec(7'b1110001, 2, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of an evaluation.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 7'b1111111;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_idle", 32'(in_ready), 1);
        chk("midrst_y_err", 32'({out_y, out_err}), 0);
        rst_n = 1'b1;
        model_clear();
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);
        set_len(6);
        run_vec(7'b1111111, 0, 0, 0, 0, 0, 0, 0);

`ifdef MAJ_NET_INV_EN
        prog_node(0, 0, 1, 2, 1);
        set_len(1);
        for (int i = 0; i < 4; i++) begin
            run_vec(N_IN'(i), 0, 0, 0, 0, 0, 0, 0);
            chk("inv_or", 32'(out_y), 32'((i & 1) | (i >> 1)));
        end
`endif

        // Random programs, inputs, lengths and backpressure.
        for (int t = 0; t < 30; t++) begin
            int mode;
            for (int n = 0; n < N_NODES; n++)
                prog_node(n, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 7));
            set_len($urandom_range(0, 15));
            for (int v = 0; v < 3; v++) begin
                mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
                if (mode == 0 && m_len > 0 && $urandom_range(0, 3) == 0) mode = 2;
                run_vec(N_IN'($urandom), $urandom_range(0, 3), mode, $urandom_range(0, 7),
                        $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                        $urandom_range(0, 7));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
